// File: rtl/int_to_float_rounding_stage.sv
// Final rounding stage of the integer-to-float converter: applies the RISC-V rounding mode to a
// truncated single-precision result and raises NX, as a two-deep valid/ready pipeline.
module int_to_float_rounding_stage #(
    parameter int         RESIDUE_WIDTH = 9,
    parameter logic [2:0] FALLBACK_RM   = 3'b000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_float,
    input  logic [RESIDUE_WIDTH-1:0] in_residue,
    input  logic                     in_is_zero,
    input  logic [2:0]               rm_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_float,
    output logic                     out_inexact,
    output logic                     out_rm_invalid
);

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Handshake: a transfer happens on any edge where valid and ready are both high; a stage
    // accepts new data when it is empty or its current content moves on in the same cycle.

    // Stage 1 state
    logic        s1_valid;
    logic [31:0] s1_float;
    logic        s1_inc;
    logic        s1_nx;
    logic        s1_rm_invalid;

    // Stage 1 combinational rounding decision
    logic       rm_reserved;
    logic [2:0] rm_eff;
    logic       round_bit;
    logic       sticky;
    logic       lsb;
    logic       sign;
    logic       inc_c;

    always_comb begin
        rm_reserved = (rm_in > RM_RMM);
        rm_eff      = rm_reserved ? FALLBACK_RM : rm_in;
        round_bit   = in_residue[RESIDUE_WIDTH-1];
        sticky      = |in_residue[RESIDUE_WIDTH-2:0];
        lsb         = in_float[0];
        sign        = in_float[31];
        inc_c       = 1'b0;
        case (rm_eff)
            RM_RNE:  inc_c = round_bit & (sticky | lsb);
            RM_RTZ:  inc_c = 1'b0;
            RM_RDN:  inc_c = sign & (round_bit | sticky);
            RM_RUP:  inc_c = ~sign & (round_bit | sticky);
            RM_RMM:  inc_c = round_bit;
            default: inc_c = 1'b0;
        endcase
    end

    // Pipeline control
    logic s1_advance;
    logic in_fire;

    always_comb begin
        s1_advance = s1_valid & (~out_valid | out_ready);
        in_ready   = ~flush & (~s1_valid | s1_advance);
        in_fire    = in_valid & in_ready;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_float      <= 32'h0;
            s1_inc        <= 1'b0;
            s1_nx         <= 1'b0;
            s1_rm_invalid <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
            if (in_fire) begin
                // A zero source forces +0.0 exactly, whatever the upstream data carries
                s1_float      <= in_is_zero ? 32'h0 : in_float;
                s1_inc        <= in_is_zero ? 1'b0 : inc_c;
                s1_nx         <= in_is_zero ? 1'b0 : (round_bit | sticky);
                s1_rm_invalid <= rm_reserved;
            end
        end
    end

    // Stage 2: mantissa increment; a carry out bumps the exponent and leaves mantissa zero
    logic [23:0] mant_sum;
    logic [7:0]  exp_rounded;
    logic [22:0] mant_rounded;

    always_comb begin
        mant_sum     = {1'b0, s1_float[22:0]} + {23'b0, s1_inc};
        exp_rounded  = s1_float[30:23] + {7'b0, mant_sum[23]};
        mant_rounded = mant_sum[23] ? 23'h0 : mant_sum[22:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_float      <= 32'h0;
            out_inexact    <= 1'b0;
            out_rm_invalid <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s1_advance) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (s1_advance) begin
                out_float      <= {s1_float[31], exp_rounded, mant_rounded};
                out_inexact    <= s1_nx;
                out_rm_invalid <= s1_rm_invalid;
            end
        end
    end

endmodule

// File: tb/tb_int_to_float_rounding_stage.sv
// Directed bench for int_to_float_rounding_stage: vector table plus stall, flush and reset sequences.
module tb_int_to_float_rounding_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_float;
    logic [8:0]  in_residue;
    logic        in_is_zero;
    logic [2:0]  rm_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_inexact;
    logic        out_rm_invalid;

    int total;
    int bad;

    typedef struct {
        logic [31:0] f;
        logic [8:0]  res;
        logic        z;
        logic [2:0]  rm;
        logic [31:0] ef;
        logic        enx;
        logic        einv;
    } vec_t;

    vec_t vecs[15];
    logic [33:0] exp_q[$];

    int_to_float_rounding_stage #(
        .RESIDUE_WIDTH(9),
        .FALLBACK_RM(3'b000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_float(in_float),
        .in_residue(in_residue),
        .in_is_zero(in_is_zero),
        .rm_in(rm_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_float(out_float),
        .out_inexact(out_inexact),
        .out_rm_invalid(out_rm_invalid)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] f, input logic [8:0] res, input logic z,
                           input logic [2:0] rm, input logic [31:0] ef, input logic enx,
                           input logic einv);
        vecs[i].f    = f;
        vecs[i].res  = res;
        vecs[i].z    = z;
        vecs[i].rm   = rm;
        vecs[i].ef   = ef;
        vecs[i].enx  = enx;
        vecs[i].einv = einv;
    endtask

    task automatic drive_vec(input vec_t v);
        in_float   = v.f;
        in_residue = v.res;
        in_is_zero = v.z;
        rm_in      = v.rm;
    endtask

    // Driver: send one vector with the sink always ready and check result and latency
    task automatic run_vec(input vec_t v, input int idx);
        int waits;
        int lat;
        @(negedge clock);
        drive_vec(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        waits = 0;
        while (!in_ready && waits < 10) begin
            @(negedge clock);
            #1;
            waits++;
        end
        check($sformatf("vec%0d in_ready", idx), {33'b0, in_ready}, 34'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 10) begin
            @(negedge clock);
            #1;
            lat++;
        end
        check($sformatf("vec%0d out_valid", idx), {33'b0, out_valid}, 34'd1);
        check($sformatf("vec%0d latency", idx), 34'(lat), 34'd2);
        check($sformatf("vec%0d result", idx), {out_float, out_inexact, out_rm_invalid},
              {v.ef, v.enx, v.einv});
    endtask

    initial begin
        int idx;
        int n_out;
        int sel[4];
        logic was_stalled;
        logic saw_full;
        logic [33:0] held;
        logic [33:0] exp_v;

        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_float   = 32'h0;
        in_residue = 9'h0;
        in_is_zero = 1'b0;
        rm_in      = 3'b000;
        out_ready  = 1'b1;

        // Vector table: inputs then hand-computed result, NX, rm_invalid
        set_vec(0,  32'h4B800000, 9'h100, 1'b0, 3'd0, 32'h4B800000, 1'b1, 1'b0);
        set_vec(1,  32'h4B800000, 9'h100, 1'b0, 3'd3, 32'h4B800001, 1'b1, 1'b0);
        set_vec(2,  32'h4B800001, 9'h100, 1'b0, 3'd0, 32'h4B800002, 1'b1, 1'b0);
        set_vec(3,  32'h4F7FFFFF, 9'h1FE, 1'b0, 3'd0, 32'h4F800000, 1'b1, 1'b0);
        set_vec(4,  32'h4F7FFFFF, 9'h1FE, 1'b0, 3'd1, 32'h4F7FFFFF, 1'b1, 1'b0);
        set_vec(5,  32'hCB800000, 9'h100, 1'b0, 3'd2, 32'hCB800001, 1'b1, 1'b0);
        set_vec(6,  32'hCB800000, 9'h100, 1'b0, 3'd3, 32'hCB800000, 1'b1, 1'b0);
        set_vec(7,  32'hCB800000, 9'h100, 1'b0, 3'd7, 32'hCB800000, 1'b1, 1'b1);
        set_vec(8,  32'h5F000000, 9'h1FF, 1'b1, 3'd0, 32'h00000000, 1'b0, 1'b0);
        set_vec(9,  32'h3F800000, 9'h0FF, 1'b0, 3'd3, 32'h3F800001, 1'b1, 1'b0);
        set_vec(10, 32'h3F800000, 9'h100, 1'b0, 3'd4, 32'h3F800001, 1'b1, 1'b0);
        set_vec(11, 32'h3F800000, 9'h000, 1'b0, 3'd3, 32'h3F800000, 1'b0, 1'b0);
        set_vec(12, 32'hCB800000, 9'h180, 1'b0, 3'd5, 32'hCB800001, 1'b1, 1'b1);
        set_vec(13, 32'h4B800000, 9'h1FF, 1'b0, 3'd2, 32'h4B800000, 1'b1, 1'b0);
        set_vec(14, 32'h4B800001, 9'h0FF, 1'b0, 3'd0, 32'h4B800001, 1'b1, 1'b0);

        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset out_valid", {33'b0, out_valid}, 34'd0);
        check("reset out_float", {2'b0, out_float}, 34'd0);
        check("reset flags", {32'b0, out_inexact, out_rm_invalid}, 34'd0);
        check("reset in_ready", {33'b0, in_ready}, 34'd1);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end
        @(negedge clock);

        // Back-to-back 4 inputs, sink stalled on cycles 3..5
        sel[0] = 2; sel[1] = 3; sel[2] = 5; sel[3] = 9;
        idx = 0;
        n_out = 0;
        was_stalled = 1'b0;
        saw_full = 1'b0;
        held = '0;
        exp_q.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            out_ready = !(c >= 3 && c <= 5);
            if (idx < 4) begin
                drive_vec(vecs[sel[idx]]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (was_stalled) begin
                check("stall hold", {out_valid, out_float, out_inexact}, {1'b1, held[33:2], held[1]});
                check("stall hold rm", {33'b0, out_rm_invalid}, {33'b0, held[0]});
            end
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("b2b unexpected output", {out_float, out_inexact, out_rm_invalid}, 34'h0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("b2b out%0d", n_out), {out_float, out_inexact, out_rm_invalid}, exp_v);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({vecs[sel[idx]].ef, vecs[sel[idx]].enx, vecs[sel[idx]].einv});
                idx++;
            end
            was_stalled = out_valid & ~out_ready;
            held = {out_float, out_inexact, out_rm_invalid};
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("b2b output count", 34'(n_out), 34'd4);
        check("b2b input count", 34'(idx), 34'd4);
        check("b2b in_ready low when full", {33'b0, saw_full}, 34'd1);

        // Flush with two in flight; the input shown alongside flush must not be accepted
        @(negedge clock);
        drive_vec(vecs[1]);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        drive_vec(vecs[2]);
        @(negedge clock);
        drive_vec(vecs[3]);
        out_ready = 1'b0;
        flush = 1'b1;
        #1;
        check("flush in_ready", {33'b0, in_ready}, 34'd0);
        check("flush pre out_valid", {33'b0, out_valid}, 34'd1);
        @(negedge clock);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("flush out_valid", {33'b0, out_valid}, 34'd0);
        n_out = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            if (out_valid) n_out++;
        end
        check("flush no ghost output", 34'(n_out), 34'd0);
        run_vec(vecs[10], 100);

        // Asynchronous reset while a result is held
        @(negedge clock);
        drive_vec(vecs[1]);
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        idx = 0;
        #1;
        while (!out_valid && idx < 10) begin
            @(negedge clock);
            #1;
            idx++;
        end
        check("pre-reset out_valid", {33'b0, out_valid}, 34'd1);
        check("pre-reset out_float", {2'b0, out_float}, {2'b0, 32'h4B800001});
        #1;
        reset = 1'b1;
        #1;
        check("async reset out_valid", {33'b0, out_valid}, 34'd0);
        check("async reset out_float", {2'b0, out_float}, 34'd0);
        check("async reset flags", {32'b0, out_inexact, out_rm_invalid}, 34'd0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("post-reset out_valid", {33'b0, out_valid}, 34'd0);
        run_vec(vecs[2], 101);

        // Report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
